// File: rtl/pc_pkg.sv
// pc_pkg: definitions shared by the program-counter generator and its return-address stack.
//   - pc_state_e    : sequencer states (boot, run, halt)
//   - Def*          : default values for the pc_gen / pc_ras parameters
//   - is_misaligned : true when an address is not a multiple of the step size
package pc_pkg;

  localparam int unsigned DefAddrW     = 8;
  localparam int unsigned DefStep      = 4;
  localparam int unsigned DefResetAddr = 0;
  localparam int unsigned DefRasDepth  = 4;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } pc_state_e;

  // Addresses are zero-extended to 32 bits before the check, so ADDR_W must not exceed 32.
  function automatic logic is_misaligned(input logic [31:0] addr, input int unsigned step);
    return (addr % step) != 32'd0;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular LIFO of RAS_DEPTH return addresses.
// When the stack is full, a push overwrites the oldest entry. A pop on an empty stack is ignored.
// A push and a pop in the same cycle pop first: the old top is returned and then replaced.
// Ports:
//   clk, rst_n  : clock; asynchronous active-low reset (empties the stack)
//   push_i      : push push_data_i
//   push_data_i : address to push
//   pop_i       : pop the top entry
//   top_o       : current top entry (meaningful only when empty_o is 0)
//   empty_o     : the stack holds no entries
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned RAS_DEPTH = DefRasDepth
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] Full   = CntW'(RAS_DEPTH);
  localparam logic [PtrW-1:0] LastIx = PtrW'(RAS_DEPTH - 1);

  // ptr_q is the slot that the next push writes; the top of the stack is the slot just below it.
  logic [PtrW-1:0]   ptr_q, ptr_d, ptr_inc, ptr_dec, wr_idx;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic              pop_ok;

  assign ptr_inc = (ptr_q == LastIx) ? '0 : ptr_q + PtrW'(1);
  assign ptr_dec = (ptr_q == '0) ? LastIx : ptr_q - PtrW'(1);
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign top_o   = mem_q[ptr_dec];
  assign empty_o = (cnt_q == '0);

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_idx = ptr_q;
    if (pop_ok && push_i) begin
      // A pop followed by a push replaces the top in place.
      wr_idx = ptr_dec;
    end else if (pop_ok) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - CntW'(1);
    end else if (push_i) begin
      ptr_d = ptr_inc;
      if (cnt_q != Full) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // The storage needs no reset: the entry count decides what is readable.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with boot, run and halt states.
// The next PC is chosen in this priority order:
//   jump, branch, return (optional), sequential increment on a transfer, hold.
// The optional return-address stack is built only when the macro PC_RAS_EN is defined.
// Ports:
//   clk, rst_n                 : clock; asynchronous active-low reset
//   halt, resume               : request to enter / leave the halt state
//   jump_valid, jump_target    : unconditional redirect
//   branch_taken,branch_target : taken-branch redirect
//   call, ret                  : push the return address / pop it and redirect (PC_RAS_EN only)
//   pc_ready                   : the fetch stage accepts pc_out this cycle
//   pc_valid, pc_out           : fetch address and its valid flag
//   misalign                   : sticky; set when an applied redirect target was not a multiple
//                                of STEP
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W                  = DefAddrW,
  parameter int unsigned STEP                    = DefStep,
  parameter logic [ADDR_W-1:0] RESET_ADDR        = ADDR_W'(DefResetAddr),
  parameter int unsigned RAS_DEPTH               = DefRasDepth
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              resume,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              call,
  input  logic              ret,
  input  logic              pc_ready,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] StepW = ADDR_W'(STEP);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic              transfer;
  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic              sel_ret;
  logic              ret_ok;
  logic [ADDR_W-1:0] ras_top;

  assign pc_valid = (state_q == StRun);
  assign pc_out   = pc_q;
  assign misalign = misalign_q;
  assign transfer = pc_valid && pc_ready;

`ifdef PC_RAS_EN
  logic ras_empty;
  logic ras_push;

  assign ret_ok   = ret && !ras_empty;
  assign ras_push = call && transfer;

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (ras_push),
    .push_data_i(pc_q + StepW),
    .pop_i      (sel_ret),
    .top_o      (ras_top),
    .empty_o    (ras_empty)
  );
`else
  logic unused_ras;

  assign unused_ras = call ^ ret;
  assign ret_ok     = 1'b0;
  assign ras_top    = '0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    redir      = 1'b0;
    redir_tgt  = '0;
    sel_ret    = 1'b0;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (jump_valid) begin
          redir     = 1'b1;
          redir_tgt = jump_target;
        end else if (branch_taken) begin
          redir     = 1'b1;
          redir_tgt = branch_target;
        end else if (ret_ok) begin
          // The stack is popped only when the return is the winning redirect.
          redir     = 1'b1;
          redir_tgt = ras_top;
          sel_ret   = 1'b1;
        end
        if (redir) begin
          pc_d = redir_tgt;
          if (is_misaligned(32'(redir_tgt), STEP)) begin
            misalign_d = 1'b1;
          end
        end else if (transfer) begin
          pc_d = pc_q + StepW;
        end
        // A redirect in the same cycle as a halt is still applied.
        if (halt) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (resume && !halt) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_ADDR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam int AddrMod = 256;
  localparam int Step    = 4;
  localparam int Depth   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halt = 1'b0, resume = 1'b0;
  logic       jump_valid = 1'b0, branch_taken = 1'b0;
  logic [7:0] jump_target = '0, branch_target = '0;
  logic       call = 1'b0, ret = 1'b0, pc_ready = 1'b1;
  logic       pc_valid, misalign;
  logic [7:0] pc_out;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 = boot, 1 = run, 2 = halt.
  int m_mode, m_pc;
  bit m_mis;
  int m_ras[$];

  pc_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .halt         (halt),
    .resume       (resume),
    .jump_valid   (jump_valid),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .call         (call),
    .ret          (ret),
    .pc_ready     (pc_ready),
    .pc_valid     (pc_valid),
    .pc_out       (pc_out),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_mis  = 1'b0;
    m_ras.delete();
  endtask

  // Applies the rules for one rising edge, using the inputs currently driven.
  task automatic model_edge();
    int  nxt = m_pc;
    bit  xfer = (m_mode == 1) && pc_ready;
    bit  have_ret;
    int  tgt = -1;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      if (resume && !halt) m_mode = 1;
    end else begin
`ifdef PC_RAS_EN
      have_ret = ret && (m_ras.size() > 0);
`else
      have_ret = 1'b0;
`endif
      if (jump_valid) tgt = int'(jump_target);
      else if (branch_taken) tgt = int'(branch_target);
      else if (have_ret) tgt = m_ras.pop_back();
      if (tgt >= 0) begin
        nxt = tgt;
        if (tgt % Step != 0) m_mis = 1'b1;
      end else if (xfer) begin
        nxt = (m_pc + Step) % AddrMod;
      end
`ifdef PC_RAS_EN
      if (call && xfer) begin
        m_ras.push_back((m_pc + Step) % AddrMod);
        if (m_ras.size() > Depth) void'(m_ras.pop_front());
      end
`endif
      m_pc = nxt;
      if (halt) m_mode = 2;
    end
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(pc_valid), 32'(m_mode == 1));
    check({tag, ".pc"}, 32'(pc_out), 32'(m_pc));
    check({tag, ".mis"}, 32'(misalign), 32'(m_mis));
  endtask

  task automatic clear_req();
    jump_valid   = 1'b0;
    branch_taken = 1'b0;
    call         = 1'b0;
    ret          = 1'b0;
    halt         = 1'b0;
    resume       = 1'b0;
  endtask

  initial begin
    logic [7:0] tgt;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(pc_valid), 32'd0);
    check("rst.pc", 32'(pc_out), 32'h00);
    check("rst.mis", 32'(misalign), 32'd0);

    // Release reset between edges; the first edge only leaves boot.
    rst_n = 1'b1;
    #1;
    check("boot.valid", 32'(pc_valid), 32'd0);
    cycle("boot");
    check("seq0", 32'(pc_out), 32'h00);
    cycle("seq1");
    check("seq1.lit", 32'(pc_out), 32'h04);
    cycle("seq2");
    check("seq2.lit", 32'(pc_out), 32'h08);

    // Stall at 0x08.
    pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      check("stall.lit", 32'(pc_out), 32'h08);
    end
    pc_ready = 1'b1;
    cycle("unstall");
    check("unstall.lit", 32'(pc_out), 32'h0C);

    // Jump beats branch.
    jump_valid = 1'b1; jump_target = 8'h40;
    branch_taken = 1'b1; branch_target = 8'h80;
    cycle("prio");
    check("prio.lit", 32'(pc_out), 32'h40);
    check("prio.mis", 32'(misalign), 32'd0);
    clear_req();

    // Wrap from 0xFC to 0x00.
    jump_valid = 1'b1; jump_target = 8'hFC;
    cycle("to_fc");
    clear_req();
    cycle("wrap");
    check("wrap.lit", 32'(pc_out), 32'h00);

`ifdef PC_RAS_EN
    jump_valid = 1'b1; jump_target = 8'h10;
    cycle("to_10");
    call = 1'b1; jump_target = 8'h50;
    cycle("call");
    check("call.lit", 32'(pc_out), 32'h50);
    clear_req();
    ret = 1'b1;
    cycle("ret");
    check("ret.lit", 32'(pc_out), 32'h14);
    clear_req();
`else
    // Without the stack, call and ret leave sequencing untouched.
    call = 1'b1; ret = 1'b1;
    cycle("noras");
    check("noras.lit", 32'(pc_out), 32'h04);
    clear_req();
`endif

    // Branch to a misaligned target together with halt, then ignore a jump while halted.
    branch_taken = 1'b1; branch_target = 8'h22; halt = 1'b1;
    cycle("br_halt");
    check("br_halt.pc", 32'(pc_out), 32'h22);
    check("br_halt.mis", 32'(misalign), 32'd1);
    clear_req();
    jump_valid = 1'b1; jump_target = 8'h60;
    cycle("halt_jump");
    check("halt_jump.pc", 32'(pc_out), 32'h22);
    clear_req();

    // Asynchronous reset while halted.
    rst_n = 1'b0;
    #2;
    model_reset();
    check("mid_rst.mis", 32'(misalign), 32'd0);
    check("mid_rst.pc", 32'(pc_out), 32'h00);
    check("mid_rst.valid", 32'(pc_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random stimulus against the model.
    for (int n = 0; n < 400; n++) begin
      jump_valid   = ($urandom_range(0, 7) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      halt         = ($urandom_range(0, 15) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      call         = ($urandom_range(0, 5) == 0);
      ret          = ($urandom_range(0, 5) == 0);
      pc_ready     = ($urandom_range(0, 3) != 0);
      tgt          = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) tgt = tgt & 8'hFC;
      jump_target  = tgt;
      tgt          = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) tgt = tgt & 8'hFC;
      branch_target = tgt;
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
